// File: rtl/mux4way_rr_pkg.sv
// Shared types and helpers for the 4-way round-robin gathering mux.
// sel_t names both the source tag on the output and the arbiter's last-grant pointer.
package mux4_pkg;

   localparam int NUM_SRC = 4;

   typedef logic [1:0] sel_t;

   // Relies on the 2-bit width so that 3 wraps back to 0.
   function automatic sel_t next_sel(sel_t cur);
      return cur + sel_t'(1);
   endfunction

endpackage

// File: rtl/mux4way_rr_if.sv
// Bundle of the four source streams and the merged output stream.
// The slave modport is the mux itself; the master modport is its surroundings.
interface mux4way_rr_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] IN1, IN2, IN3, IN4;
   logic             v1, v2, v3, v4;
   logic             r1, r2, r3, r4;
   logic [WIDTH-1:0] OUT;
   logic [1:0]       s;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  IN1, IN2, IN3, IN4,
      input  v1, v2, v3, v4,
      output r1, r2, r3, r4,
      output OUT, s, out_valid,
      input  out_ready
   );

   modport master (
      output IN1, IN2, IN3, IN4,
      output v1, v2, v3, v4,
      input  r1, r2, r3, r4,
      input  OUT, s, out_valid,
      output out_ready
   );

endinterface

// File: rtl/mux4way_rr_arbiter.sv
// Four-requester round-robin arbiter; owns the last-grant pointer.
// The grant is combinational and is forced to zero while rst is high.
module rr_arbiter4
   import mux4_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] req,
   input  logic               en,
   output logic [NUM_SRC-1:0] gnt,
   output sel_t               gnt_idx
);

   sel_t last_q, last_d;
   sel_t cand;
   logic found;

   // Walk the requesters starting just after the last winner.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      found   = 1'b0;
      cand    = next_sel(last_q);
      gnt_idx = next_sel(last_q);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
         cand = next_sel(cand);
      end
   end

   always_comb begin
      gnt = '0;
      if (found && en && !rst) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   // The pointer moves only when a grant is actually issued.
   always_comb begin
      last_d = last_q;
      if (|gnt) begin
         last_d = gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
      if (rst) begin
         last_q <= sel_t'(NUM_SRC - 1);
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mux4way_rr.sv
// Merges four valid/ready source streams into one registered output stream,
// tagging each word with the index of the source it came from.
module mux4way_rr
   import mux4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   mux4way_rr_if.slave    bus
);

   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] gnt;
   sel_t               gnt_idx;
   logic               load;

   logic [WIDTH-1:0]   data_sel;
   logic [WIDTH-1:0]   out_q, out_d;
   sel_t               s_q, s_d;
   logic               valid_q, valid_d;

   assign req  = {bus.v4, bus.v3, bus.v2, bus.v1};

   // The holding register may refill in the same cycle it drains.
   assign load = !valid_q || bus.out_ready;

   rr_arbiter4 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .en      (load),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      data_sel = bus.IN1;
      unique case (gnt_idx)
         2'd0: data_sel = bus.IN1;
         2'd1: data_sel = bus.IN2;
         2'd2: data_sel = bus.IN3;
         2'd3: data_sel = bus.IN4;
         default: data_sel = bus.IN1;
      endcase
   end

   always_comb begin
      out_d   = out_q;
      s_d     = s_q;
      valid_d = valid_q;
      if (|gnt) begin
         out_d   = data_sel;
         s_d     = gnt_idx;
         valid_d = 1'b1;
      end else if (valid_q && bus.out_ready) begin
         // Drained with nothing to replace it: data and tag keep their last value.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         s_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         s_q     <= s_d;
         valid_q <= valid_d;
      end
   end

   assign bus.r1        = gnt[0];
   assign bus.r2        = gnt[1];
   assign bus.r3        = gnt[2];
   assign bus.r4        = gnt[3];
   assign bus.OUT       = out_q;
   assign bus.s         = s_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux4way_rr.sv
// Directed and randomized checks of mux4way_rr against a small transaction-level model.
module tb_mux4way_rr;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mux4way_rr_if #(.WIDTH(8)) bus ();

   mux4way_rr #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int check_cnt = 0;

   // Reference model state: what the consumer should see and who won last.
   logic [7:0] d [4];
   logic       m_valid;
   logic [7:0] m_out;
   int         m_s;
   int         m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // First source at or after last+1 (mod 4) that is requesting, or -1.
   function automatic int pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (v[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic cycle(input logic [3:0] v, input logic ordy, input logic rst_i);
      int         g;
      logic [3:0] exp_r;
      rst           = rst_i;
      bus.v1        = v[0];
      bus.v2        = v[1];
      bus.v3        = v[2];
      bus.v4        = v[3];
      bus.IN1       = d[0];
      bus.IN2       = d[1];
      bus.IN3       = d[2];
      bus.IN4       = d[3];
      bus.out_ready = ordy;
      #1;
      g     = (rst_i || !(!m_valid || ordy)) ? -1 : pick(v, m_last);
      exp_r = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check("ready", 32'({bus.r4, bus.r3, bus.r2, bus.r1}), 32'(exp_r));
      @(posedge clk);
      if (rst_i) begin
         m_valid = 1'b0;
         m_out   = 8'h00;
         m_s     = 0;
         m_last  = 3;
      end else if (g >= 0) begin
         m_out   = d[g];
         m_s     = g;
         m_valid = 1'b1;
         m_last  = g;
      end else if (m_valid && ordy) begin
         m_valid = 1'b0;
      end
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("OUT", 32'(bus.OUT), 32'(m_out));
      check("s", 32'(bus.s), 32'(m_s));
   endtask

   initial begin
      logic [7:0] seq [4];
      d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
      m_valid = 1'b0; m_out = 8'h00; m_s = 0; m_last = 3;

      // Reset with every source requesting: no ready may rise.
      cycle(4'b1111, 1'b1, 1'b1);
      cycle(4'b1111, 1'b1, 1'b1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_OUT", 32'(bus.OUT), 32'h00);

      // Single source IN3.
      d[2] = 8'hA5;
      cycle(4'b0100, 1'b1, 1'b0);
      check("single_OUT", 32'(bus.OUT), 32'hA5);
      check("single_s", 32'(bus.s), 32'd2);

      // All valid, continuous accept: strict rotation from IN1.
      cycle(4'b0000, 1'b0, 1'b1);
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
      seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1111, 1'b1, 1'b0);
         check("rr_OUT", 32'(bus.OUT), 32'(seq[i % 4]));
         check("rr_s", 32'(bus.s), 32'(i % 4));
      end

      // Backpressure: hold IN1's word while IN2/IN4 wait.
      cycle(4'b0000, 1'b0, 1'b1);
      d[0] = 8'h01; d[1] = 8'h02; d[3] = 8'h04;
      cycle(4'b0001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(4'b1010, 1'b0, 1'b0);
         check("bp_OUT", 32'(bus.OUT), 32'h01);
         check("bp_s", 32'(bus.s), 32'd0);
      end
      cycle(4'b1010, 1'b1, 1'b0);
      check("bp_rel1_s", 32'(bus.s), 32'd1);
      cycle(4'b1010, 1'b1, 1'b0);
      check("bp_rel2_s", 32'(bus.s), 32'd3);

      // Pointer at 3, IN1 idle: IN2, IN4, IN2.
      cycle(4'b1010, 1'b1, 1'b0);
      check("skip1_s", 32'(bus.s), 32'd1);
      cycle(4'b1010, 1'b1, 1'b0);
      check("skip2_s", 32'(bus.s), 32'd3);
      cycle(4'b1010, 1'b1, 1'b0);
      check("skip3_s", 32'(bus.s), 32'd1);

      // Drain with no requests; pointer must stay on IN2 so IN4 wins next.
      cycle(4'b0000, 1'b1, 1'b0);
      check("drain_valid", 32'(bus.out_valid), 32'd0);
      check("drain_OUT", 32'(bus.OUT), 32'h02);
      cycle(4'b1010, 1'b1, 1'b0);
      check("drain_ptr_s", 32'(bus.s), 32'd3);

      // Reset while holding IN3's word with everyone requesting.
      cycle(4'b0000, 1'b1, 1'b0);
      d[2] = 8'h33;
      cycle(4'b0100, 1'b0, 1'b0);
      check("mid_hold_OUT", 32'(bus.OUT), 32'h33);
      cycle(4'b1111, 1'b0, 1'b1);
      check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_OUT", 32'(bus.OUT), 32'h00);
      cycle(4'b1111, 1'b1, 1'b0);
      check("mid_first_s", 32'(bus.s), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         for (int j = 0; j < 4; j++) d[j] = 8'($urandom);
         cycle(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/mux4way_rr.md
Name: mux4way_rr

Overview:
- Gathering counterpart of the 4-way demultiplexer: merges four independent valid/ready source streams into one output stream.
- Uses a round-robin arbiter and a single output holding register.
- Each accepted word carries a 2-bit select tag `s` naming its source, so a downstream 4-way demux can route it back by the same index.
- Sits between four producers and one shared consumer in the datapath.

Parameters:
- WIDTH, 8, data width of every input and the output.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- IN1, IN2, IN3, IN4  input  WIDTH  source data.
- v1, v2, v3, v4  input  1  source valid.
- r1, r2, r3, r4  output  1  source ready; a transfer occurs when vN and rN are both high at a clk edge.
- OUT  output  WIDTH  registered output data.
- s  output  2  registered source tag of OUT: 0=IN1, 1=IN2, 2=IN3, 3=IN4.
- out_valid  output  1  OUT/s hold a word.
- out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.

Behaviour:
- Reset (rst high at a clk edge): out_valid=0, OUT=0, s=0, last-grant pointer=3 (IN1 has top priority). Reset wins over any simultaneous handshake; a word held at reset is discarded.
- While rst is high, r1..r4 are held at 0 combinationally.
- load = !out_valid || out_ready. Combinational; the register may refill in the same cycle it drains.
- Arbitration:
  - Combinational.
  - Search order starts at (last+1) mod 4 and wraps.
  - The first N with vN=1 is granted; grant is valid only if load=1.
  - rN = 1 only for the granted N; all others 0. At most one rN is high per cycle.
  - rN never depends on out_ready except through load.
- On a clk edge with a grant:
  - OUT <= INg, s <= g-1 (2-bit), out_valid <= 1, last <= g-1.
- On a clk edge with no grant:
  - If out_valid && out_ready: out_valid <= 0; OUT and s hold their old value.
  - Otherwise all state holds.
- Latency: source transfer to out_valid is 1 cycle.
- Throughput: 1 word/cycle when out_ready is held high and any source is valid.
- Fairness: with all four valid continuously and out_ready=1, grants run 0,1,2,3,0,... Any source waits at most 3 transfers.
- The pointer advances only on a grant; idle cycles do not move it.
- Backpressure: while out_valid=1 and out_ready=0, all rN=0, and OUT/s stay stable until accepted.
- Source data need not be stable before rN; sampling happens only on the transfer edge.

Decomposition:
- Package mux4_pkg:
  - localparam NUM_SRC=4.
  - typedef logic [1:0] sel_t (used for s and the pointer).
  - function next_sel(sel_t) for wrap-around increment.
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], en, clk, rst.
  - Outputs: one-hot gnt[3:0], gnt_idx sel_t.
  - Owns the last-grant pointer.
- mux4way_rr instantiates rr_arbiter4 with en=load and adds the output register plus the data mux.

Test Plan:
- Reset then single source: v3=1, IN3=8'hA5, out_ready=1 → r3=1 in that cycle; next cycle OUT=8'hA5, s=2, out_valid=1.
- All valid, out_ready=1 for 8 cycles:
  - Stimulus: IN1..IN4 = 8'h11, 8'h22, 8'h33, 8'h44.
  - Response: OUT sequence 11,22,33,44,11,22,33,44; s sequence 0,1,2,3,0,1,2,3.
- Backpressure:
  - Fill with v1 (IN1=8'h01), then out_ready=0 for 4 cycles with v2=v4=1.
  - Response: OUT=8'h01 and s=0 held; r1..r4=0. Raise out_ready → next word from IN2 (s=1), then IN4 (s=3).
- Pointer wrap and skip: last grant=3; v1=0, v2=1, v4=1 → IN2 granted first, then IN4, then IN2.
- Drain with no new request: out_valid=1, out_ready=1, all vN=0 → out_valid=0 next cycle; OUT unchanged; pointer unchanged.
- Reset mid-operation:
  - Stimulus: out_valid=1 holding 8'h33, all vN=1, assert rst for one cycle.
  - Response: out_valid=0, OUT=0, s=0, all rN=0 during rst. After release, first grant goes to IN1.
